// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the RV32I pipeline hazard scheduler:
//   forwarding-select encodings, scheduler FSM state encoding and the
//   scoreboard entry record kept for each in-flight stage.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  // EX operand source selects
  localparam logic [1:0] FWD_RF    = 2'b00;  // register file read value
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX-MEM ALU result
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM-WB writeback data
  localparam logic [1:0] FWD_DRAM  = 2'b11;  // MEM-stage DRAM read data

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FREEZE = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } sb_entry_t;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/hazard_fwd_mux_sel.sv
//------------------------------------------------------------------------------
// hazard_fwd_mux_sel
//   Forwarding priority for one EX operand. The MEM-stage producer is younger
//   than the WB-stage producer, so it is checked first.
//   Ports:
//     rs, rs_re             operand index and read flag of the EX instruction
//     mem                   MEM-stage scoreboard entry
//     wb_valid/wb_rd/wb_we  WB-stage scoreboard fields
//     sel                   operand source select (pipe_pkg FWD_* encoding)
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_fwd_mux_sel
  import pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       rs_re,
  input  sb_entry_t  mem,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       wb_we,
  output logic [1:0] sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem.valid & mem.we & (mem.rd == rs);
  assign wb_hit  = wb_valid  & wb_we  & (wb_rd  == rs);

  always_comb begin
    sel = FWD_RF;
    // x0 is hard-wired zero and never forwarded
    if (rs_re && (rs != 5'd0)) begin
      if (mem_hit) begin
        sel = mem.is_load ? FWD_DRAM : FWD_EXMEM;
      end else if (wb_hit) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule : hazard_fwd_mux_sel

`default_nettype wire

// File: rtl/hazard_sched.sv
//------------------------------------------------------------------------------
// hazard_sched
//   Pipeline hazard scheduler for the 5-stage RV32I core. Keeps a scoreboard
//   of the instructions in EX/MEM/WB and derives stall, flush, freeze and
//   EX forwarding selects for the instruction currently in ID.
//   Optional feature macro: HAZARD_PERF_EN (saturating stall/flush counters;
//   when undefined the counter ports read 0 and no counter flops exist).
//   Ports:
//     clk, rst_cpu                core clock, synchronous active-low reset
//     id_*                        decoded fields of the instruction in ID
//     ex_branch_taken             EX resolved a taken branch / jal / jalr
//     dram_busy                   data memory not ready this cycle
//     pc_stall, ifid_stall        hold PC / IF-ID
//     ifid_flush, idex_flush      bubble into IF-ID / ID-EX
//     freeze                      hold ID-EX, EX-MEM, MEM-WB
//     fwd_a_sel, fwd_b_sel        EX operand source selects
//     perf_stall_cnt/flush_cnt    event counters
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_sched
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_cpu,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_re,
  input  logic        id_rs2_re,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_we,
  input  logic        id_is_load,
  input  logic        ex_branch_taken,
  input  logic        dram_busy,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        freeze,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  // ---------------------------------------------------------------------------
  // Scoreboard and FSM state
  // ---------------------------------------------------------------------------
  sb_entry_t    ex_q;
  logic [4:0]   ex_rs1_q;
  logic [4:0]   ex_rs2_q;
  logic         ex_rs1_re_q;
  logic         ex_rs2_re_q;
  sb_entry_t    mem_q;
  // The WB entry drops the load flag: MEM-WB writeback data already carries
  // the loaded value, so the source select does not depend on it.
  logic         wb_valid_q;
  logic [4:0]   wb_rd_q;
  logic         wb_we_q;

  sched_state_e state_q;
  sched_state_e state_d;
  logic         pend_q;
  logic         pend_d;

  logic         load_use;
  logic         take_flush;
  logic [1:0]   fwd_a_raw;
  logic [1:0]   fwd_b_raw;

  assign load_use = id_valid & ex_q.valid & ex_q.is_load & ex_q.we &
                    (ex_q.rd != 5'd0) &
                    ((id_rs1_re & (id_rs1 == ex_q.rd)) |
                     (id_rs2_re & (id_rs2 == ex_q.rd)));

  // ---------------------------------------------------------------------------
  // FSM next state and control outputs
  // freeze follows dram_busy in the same cycle; the FREEZE state remembers
  // that the previous cycle was frozen so a branch resolved while frozen can
  // be replayed as a flush in the first free cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pend_d     = 1'b0;
    take_flush = 1'b0;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    freeze     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (dram_busy) begin
          state_d = ST_FREEZE;
          pend_d  = ex_branch_taken;
        end else begin
          take_flush = ex_branch_taken;
        end
      end
      ST_FREEZE: begin
        if (dram_busy) begin
          pend_d = pend_q | ex_branch_taken;
        end else begin
          state_d    = ST_RUN;
          take_flush = pend_q | ex_branch_taken;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (dram_busy) begin
      freeze     = 1'b1;
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
    end else if (take_flush) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end

    // All control outputs are quiet while reset is asserted
    if (!rst_cpu) begin
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      freeze     = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register and scoreboard advance
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_cpu) begin
      state_q     <= ST_RUN;
      pend_q      <= 1'b0;
      ex_q        <= '0;
      ex_rs1_q    <= 5'd0;
      ex_rs2_q    <= 5'd0;
      ex_rs1_re_q <= 1'b0;
      ex_rs2_re_q <= 1'b0;
      mem_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_we_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (!freeze) begin
        wb_valid_q  <= mem_q.valid;
        wb_rd_q     <= mem_q.rd;
        wb_we_q     <= mem_q.we;
        mem_q       <= ex_q;
        ex_q        <= '{valid:   id_valid & ~idex_flush,
                         rd:      id_rd,
                         we:      id_rd_we,
                         is_load: id_is_load};
        ex_rs1_q    <= id_rs1;
        ex_rs2_q    <= id_rs2;
        ex_rs1_re_q <= id_rs1_re;
        ex_rs2_re_q <= id_rs2_re;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding selects (only meaningful when the EX entry is real)
  // ---------------------------------------------------------------------------
  hazard_fwd_mux_sel u_fwd_a (
    .rs       (ex_rs1_q),
    .rs_re    (ex_rs1_re_q & ex_q.valid),
    .mem      (mem_q),
    .wb_valid (wb_valid_q),
    .wb_rd    (wb_rd_q),
    .wb_we    (wb_we_q),
    .sel      (fwd_a_raw)
  );

  hazard_fwd_mux_sel u_fwd_b (
    .rs       (ex_rs2_q),
    .rs_re    (ex_rs2_re_q & ex_q.valid),
    .mem      (mem_q),
    .wb_valid (wb_valid_q),
    .wb_rd    (wb_rd_q),
    .wb_we    (wb_we_q),
    .sel      (fwd_b_raw)
  );

  assign fwd_a_sel = rst_cpu ? fwd_a_raw : FWD_RF;
  assign fwd_b_sel = rst_cpu ? fwd_b_raw : FWD_RF;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        stall_evt;
  logic        flush_evt;

  // A load-use stall is the only case with a stall plus ID-EX flush and no
  // IF-ID flush; a freeze never raises a flush, so it is never counted.
  assign stall_evt = pc_stall & idex_flush & ~ifid_flush & ~freeze;
  assign flush_evt = ifid_flush & ~freeze;

  always_ff @(posedge clk) begin
    if (!rst_cpu) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = rst_cpu ? stall_cnt_q : 32'd0;
  assign perf_flush_cnt = rst_cpu ? flush_cnt_q : 32'd0;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule : hazard_sched

`default_nettype wire
